// File: rtl/rst_seq_ctrl.sv
// Avalon-MM reset sequencer: collects POR/SW/EXT/WDT requests and drives a
// staggered periph/CPU reset pair. Registers are cleared only by system rst.
`timescale 1ns/1ps
module rst_seq_ctrl #(
    parameter int HOLD_W   = 16,
    parameter int DEF_HOLD = 16,
    parameter int STAGGER  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic        chipselect,
    input  logic        ext_req,
    output logic        cpu_reset,
    output logic        periph_reset,
    output logic        busy
);
    localparam int SC_W = $clog2(STAGGER + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_ASSERT,
        ST_STAG
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [SC_W-1:0]   stag_cnt_q, stag_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              wdt_en_q, wdt_en_d;
    logic [31:0]       wdt_load_q, wdt_load_d;
    logic [31:0]       wdt_cnt_q, wdt_cnt_d;
    logic [1:0]        cause_q, cause_d;
    logic [2:0]        sync_q, sync_d;

    logic wr_en, wr_ctrl, wr_hold, wr_wdt;
    logic trig_sw, trig_ext, trig_wdt;

    assign wr_en    = chipselect & write;
    assign wr_ctrl  = wr_en && (address == 2'd0);
    assign wr_hold  = wr_en && (address == 2'd1);
    assign wr_wdt   = wr_en && (address == 2'd2);
    assign trig_sw  = wr_ctrl & writedata[0];
    assign trig_ext = sync_q[1] & ~sync_q[2];
    assign trig_wdt = wdt_en_q && (wdt_cnt_q == 32'd0);

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stag_cnt_d = stag_cnt_q;
        hold_d     = hold_q;
        wdt_en_d   = wdt_en_q;
        wdt_load_d = wdt_load_q;
        wdt_cnt_d  = wdt_cnt_q;
        cause_d    = cause_q;
        sync_d     = {sync_q[1:0], ext_req};

        if (wr_ctrl) wdt_en_d = writedata[1];
        if (wr_hold) begin
            hold_d = (writedata[HOLD_W-1:0] == '0) ?
                     HOLD_W'(1) : writedata[HOLD_W-1:0];
        end
        if (wr_wdt) wdt_load_d = writedata;
        if (state_q == ST_RUN && wdt_en_q && wdt_cnt_q != 32'd0)
            wdt_cnt_d = wdt_cnt_q - 32'd1;

        unique case (state_q)
            ST_RUN: begin
                if (trig_wdt || trig_ext || trig_sw) begin
                    state_d    = ST_ASSERT;
                    hold_cnt_d = hold_q;
                    wdt_en_d   = 1'b0;
                    cause_d    = trig_wdt ? 2'd3 :
                                 trig_ext ? 2'd2 : 2'd1;
                end
            end
            ST_ASSERT: begin
                if (hold_cnt_q <= HOLD_W'(1)) begin
                    state_d    = ST_STAG;
                    stag_cnt_d = SC_W'(STAGGER);
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            ST_STAG: begin
                if (stag_cnt_q <= SC_W'(1)) begin
                    state_d   = ST_RUN;
                    wdt_cnt_d = wdt_load_q;
                end else begin
                    stag_cnt_d = stag_cnt_q - SC_W'(1);
                end
            end
            default: state_d = ST_ASSERT;
        endcase

        // A kick lands on the counter even over the end-of-sequence reload
        if (wr_wdt) wdt_cnt_d = writedata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ASSERT;
            hold_cnt_q <= HOLD_W'(DEF_HOLD);
            stag_cnt_q <= '0;
            hold_q     <= HOLD_W'(DEF_HOLD);
            wdt_en_q   <= 1'b0;
            wdt_load_q <= '1;
            wdt_cnt_q  <= '1;
            cause_q    <= 2'd0;
            sync_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            stag_cnt_q <= stag_cnt_d;
            hold_q     <= hold_d;
            wdt_en_q   <= wdt_en_d;
            wdt_load_q <= wdt_load_d;
            wdt_cnt_q  <= wdt_cnt_d;
            cause_q    <= cause_d;
            sync_q     <= sync_d;
        end
    end

    assign busy         = (state_q != ST_RUN);
    assign cpu_reset    = (state_q != ST_RUN);
    assign periph_reset = (state_q == ST_ASSERT);

    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0: readdata = {30'd0, wdt_en_q, 1'b0};
            2'd1: readdata = 32'(hold_q);
            2'd2: readdata = wdt_cnt_q;
            2'd3: readdata = {29'd0, busy, cause_q};
            default: readdata = '0;
        endcase
    end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a cycle-age reference model.
`timescale 1ns/1ps
module tb_rst_seq_ctrl;
    localparam int DEF = 16;
    localparam int STG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  address = 2'd0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        write = 1'b0;
    logic        chipselect = 1'b0;
    logic        ext_req = 1'b0;
    logic        cpu_reset, periph_reset, busy;

    int n_checks = 0;
    int n_fail = 0;

    // reference model: a sequence is "active" with an age in cycles
    bit          m_active;
    int          m_age, m_hold_used;
    logic [1:0]  m_cause;
    logic [15:0] m_hold;
    bit          m_wen;
    logic [31:0] m_load, m_cnt;
    bit          h1, h2, h3;

    rst_seq_ctrl #(.HOLD_W(16), .DEF_HOLD(DEF), .STAGGER(STG)) dut (
        .clk(clk), .rst(rst), .address(address),
        .writedata(writedata), .readdata(readdata),
        .write(write), .chipselect(chipselect), .ext_req(ext_req),
        .cpu_reset(cpu_reset), .periph_reset(periph_reset), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0: return {30'd0, m_wen, 1'b0};
            2'd1: return {16'd0, m_hold};
            2'd2: return m_cnt;
            default: return {29'd0, m_active, m_cause};
        endcase
    endfunction

    task automatic model_edge();
        bit we, was_run, t_wdt, t_ext, t_sw;
        logic [31:0] old_load;
        logic [15:0] old_hold;
        if (rst) begin
            m_active = 1; m_age = 0; m_hold_used = DEF;
            m_hold = 16'(DEF); m_wen = 0; m_load = '1; m_cnt = '1;
            m_cause = 0; h1 = 0; h2 = 0; h3 = 0;
        end else begin
            we = chipselect && write;
            was_run = !m_active;
            t_wdt = was_run && m_wen && (m_cnt == 0);
            t_ext = was_run && h2 && !h3;
            t_sw  = was_run && we && address == 2'd0 && writedata[0];
            old_load = m_load;
            old_hold = m_hold;
            h3 = h2; h2 = h1; h1 = ext_req;
            if (was_run && m_wen && m_cnt != 0) m_cnt = m_cnt - 1;
            if (we && address == 2'd0) m_wen = writedata[1];
            if (we && address == 2'd1)
                m_hold = (writedata[15:0] == 0) ? 16'd1 : writedata[15:0];
            if (we && address == 2'd2) m_load = writedata;
            if (t_wdt || t_ext || t_sw) begin
                m_active = 1; m_age = 0; m_hold_used = int'(old_hold);
                m_cause = t_wdt ? 2'd3 : t_ext ? 2'd2 : 2'd1;
                m_wen = 0;
            end else if (m_active) begin
                m_age++;
                if (m_age == m_hold_used + STG) begin
                    m_active = 0;
                    m_cnt = old_load;
                end
            end
            if (we && address == 2'd2) m_cnt = writedata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("periph", 32'(periph_reset), 32'(m_active && m_age < m_hold_used));
        chk("cpu", 32'(cpu_reset), 32'(m_active));
        chk("busy", 32'(busy), 32'(m_active));
        chk("rdata", readdata, exp_rd(address));
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1; write = 1; address = a; writedata = d;
        tick();
        chipselect = 0; write = 0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic measure(output int tp, output int tc);
        int k;
        tp = -1; tc = -1; k = 0;
        while (tc < 0 && k < 1000) begin
            tick();
            k++;
            if (tp < 0 && !periph_reset) tp = k;
            if (!cpu_reset) tc = k;
        end
    endtask

    initial begin
        int tp, tc, k, seen;
        logic [31:0] d;
        bit prev;

        // POR
        rst = 1;
        repeat (5) tick();
        rst = 0;
        measure(tp, tc);
        chk("por_periph", tp, 16);
        chk("por_cpu", tc, 20);
        rd(2'd3, d); chk("por_status", d, 0);

        // SW reset
        wr(2'd1, 3);
        rd(2'd1, d); chk("hold_rd", d, 3);
        wr(2'd0, 1);
        measure(tp, tc);
        chk("sw_periph", tp, 3);
        chk("sw_cpu", tc, 7);
        rd(2'd3, d); chk("sw_status", d, 1);
        rd(2'd1, d); chk("hold_keep", d, 3);
        wr(2'd1, 0);
        rd(2'd1, d); chk("hold_zero", d, 1);
        wr(2'd1, 3);

        // watchdog timeout
        wr(2'd2, 10);
        wr(2'd0, 2);
        k = 0;
        while (!busy && k < 200) begin tick(); k++; end
        chk("wdt_lat", k, 11);
        rd(2'd3, d); chk("wdt_cause", d[1:0], 3);
        rd(2'd0, d); chk("wdt_en_clr", d, 0);
        measure(tp, tc);

        // watchdog kicked every 8 cycles never fires
        wr(2'd2, 10);
        wr(2'd0, 2);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            repeat (7) begin tick(); if (busy) seen++; end
            wr(2'd2, 10);
        end
        chk("wdt_kick", seen, 0);
        wr(2'd0, 0);

        // external request latency
        ext_req = 1; tick(); tick();
        ext_req = 0;
        chk("ext_pre", 32'(busy), 0);
        tick();
        chk("ext_lat", 32'(busy), 1);
        rd(2'd3, d); chk("ext_cause", d[1:0], 2);
        measure(tp, tc);
        ext_req = 1; seen = 0; prev = busy;
        repeat (100) begin
            tick();
            if (busy && !prev) seen++;
            prev = busy;
        end
        chk("ext_once", seen, 1);
        ext_req = 0;
        repeat (10) tick();

        // SW write in the same cycle as a WDT timeout
        wr(2'd2, 5);
        wr(2'd0, 2);
        repeat (5) tick();
        wr(2'd0, 1);
        chk("coll_busy", 32'(busy), 1);
        rd(2'd3, d); chk("coll_cause", d[1:0], 3);
        measure(tp, tc);

        // SW write during ASSERT is ignored
        wr(2'd0, 1);
        wr(2'd0, 1);
        measure(tp, tc);
        chk("swmid_periph", tp, 2);
        chk("swmid_cpu", tc, 6);
        rd(2'd3, d); chk("swmid_cause", d[1:0], 1);

        // rst during STAGGER_REL
        wr(2'd0, 1);
        repeat (4) tick();
        chk("stg_periph", 32'(periph_reset), 0);
        chk("stg_cpu", 32'(cpu_reset), 1);
        rst = 1;
        tick();
        chk("rst_reassert", 32'(periph_reset), 1);
        rst = 0;
        measure(tp, tc);
        chk("rst_periph", tp, 16);
        chk("rst_cpu", tc, 20);
        rd(2'd3, d); chk("rst_cause", d, 0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 19) == 0) ext_req = ~ext_req;
            address = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 7) == 0);
            write = ($urandom_range(0, 3) != 0);
            case (address)
                2'd0: writedata = {$urandom_range(0, 1) == 0 ?
                                   30'd0 : 30'($urandom), 2'($urandom)};
                2'd1: writedata = 32'($urandom_range(0, 6));
                2'd2: writedata = 32'($urandom_range(0, 40));
                default: writedata = $urandom;
            endcase
            if (writedata[0] && address == 2'd0 && $urandom_range(0, 3) != 0)
                writedata[0] = 1'b0;
            tick();
        end
        rst = 0; chipselect = 0; write = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Avalon memory-mapped reset sequencer for the soft-CPU subsystem. It collects reset requests from power-on, software, an external push-button and a built-in watchdog. For each request it drives a sequenced reset pair: both outputs are held for a programmable time, the peripheral reset is released first, and the CPU reset is released a fixed stagger later. Its registers are reset only by the system reset, so configuration and last-cause status survive every CPU/peripheral reset it generates.

## Interface
- `HOLD_W`, 16: width of the hold-time register/counter.
- `DEF_HOLD`, 16: hold-time register value after `rst` (cycles both resets are held).
- `STAGGER`, 4: cycles between peripheral and CPU reset release; must be ≥1.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock.
- `rst`, in, 1: system reset, synchronous, active-high.
- `address`, in, 2: register select (word address).
- `writedata`, in, 32: write data.
- `readdata`, out, 32: read data, combinational from `address`, zero wait states.
- `write`, in, 1: write strobe.
- `chipselect`, in, 1: slave select; a write takes effect only when `chipselect && write`.
- `ext_req`, in, 1: asynchronous, debounced button request, active-high.
- `cpu_reset`, out, 1: CPU reset, active-high.
- `periph_reset`, out, 1: peripheral reset, active-high.
- `busy`, out, 1: sequence in progress (state ≠ RUN).

## Operation
Register map:
- **0 CTRL**
  - Write bit0 = 1: software reset request (self-clearing, reads 0).
  - Bit1 `wdt_en`: read/write.
- **1 HOLD**
  - Bits [HOLD_W-1:0]: hold cycles.
  - A write of 0 stores 1.
  - Upper bits read 0.
- **2 WDT**
  - 32-bit watchdog load value.
  - Any write also loads the watchdog counter ("kick").
  - Reads return the live counter.
- **3 STATUS** (read-only; writes ignored)
  - Bits [1:0]: last cause (0 = POR, 1 = SW, 2 = EXT, 3 = WDT).
  - Bit2: busy.

Reset values:
- CTRL.wdt_en = 0; HOLD = DEF_HOLD; WDT load and counter = 0xFFFF_FFFF; cause = 0.
- `cpu_reset` = `periph_reset` = `busy` = 1.
- While `rst` is high, the FSM is forced to ASSERT with the hold counter = HOLD.

FSM states: RUN, ASSERT, STAGGER_REL.
- **RUN**
  - Outputs: all outputs 0.
  - Transition: any trigger → ASSERT. On entry to ASSERT, the hold counter is loaded from HOLD, the cause is recorded, and `wdt_en` is cleared.
- **ASSERT**
  - Outputs: `periph_reset` = `cpu_reset` = 1.
  - Duration: stays exactly HOLD cycles, counter decrementing.
  - Transition: → STAGGER_REL with the stagger counter = STAGGER.
- **STAGGER_REL**
  - Outputs: `periph_reset` = 0, `cpu_reset` = 1.
  - Duration: stays exactly STAGGER cycles.
  - Transition: → RUN, reloading the watchdog counter from its load value.

Outputs decode directly from the state register, so they are glitch-free.

Triggers (evaluated in RUN only):
- SW: CTRL write with bit0 = 1.
- EXT: `ext_req` passes a 2-flop synchronizer plus a registered copy; a 0→1 edge of the synchronized value triggers.
- WDT: `wdt_en` = 1 and counter = 0. The counter decrements by 1 per cycle in RUN while `wdt_en` = 1 and saturates at 0.

Priority on simultaneous triggers, for cause recording: WDT > EXT > SW. Exactly one sequence starts.

Boundary behaviour:
- Triggers arriving during ASSERT/STAGGER_REL are dropped (no restart, no queueing). An EXT edge detected mid-sequence is lost.
- `rst` mid-sequence restarts the sequence as POR with the full current DEF_HOLD count.
- Register writes are accepted in every state. A HOLD write during a sequence affects only the next sequence.
- A WDT write in the same cycle as a WDT timeout: the timeout wins in that cycle.
- A CTRL write setting `wdt_en` in the same cycle a sequence starts: the clear wins.
- WDT load = 0 with `wdt_en` = 1 triggers on the cycle after the counter reaches 0.

## Timing
- Trigger sampled at edge T gives ASSERT from cycle T+1. `busy`, `cpu_reset` and `periph_reset` are high from T+1.
- `periph_reset` falls at T+1+HOLD.
- `cpu_reset` falls at T+1+HOLD+STAGGER. `busy` falls in the same cycle.
- After `rst` deasserts at edge R, `periph_reset` falls at R+HOLD and `cpu_reset` at R+HOLD+STAGGER.
- EXT latency: 3 edges from `ext_req` first sampled high to ASSERT.
- Readdata: combinational. A register written at edge T reads the new value from T+1.

## Test plan
1. **POR.** `rst` high 5 cycles, then low at edge R with DEF_HOLD = 16, STAGGER = 4. Expect `periph_reset` low at R+16, `cpu_reset` low at R+20, STATUS = 0.
2. **SW reset.** Write HOLD = 3, then CTRL = 1 at edge T. Expect both resets high T+1..T+3, `periph_reset` low at T+4, `cpu_reset` low at T+8, STATUS[1:0] = 1. HOLD still reads 3. Also write HOLD = 0 and expect readback 1.
3. **Watchdog.** Set WDT = 10 and CTRL = 2. Expect the counter to reach 0 and a sequence to start one cycle later with cause 3 and `wdt_en` reading 0. A repeat with a WDT write every 8 cycles never triggers.
4. **External.** Pulse `ext_req` high 2 cycles from edge E. Expect ASSERT at E+3 and cause 2. Holding `ext_req` high for 100 cycles gives only one sequence.
5. **Collisions.**
   - SW write in the same cycle as a WDT timeout: one sequence, cause 3.
   - SW write during ASSERT: ignored, release timing unchanged.
6. **`rst` during STAGGER_REL.** Expect `periph_reset` to re-assert the cycle after `rst` is sampled high, then a full POR sequence with cause 0.
